// File: rtl/pipeline_control.sv
// ---------------------------------------------------------------------------
// pipeline_control
//
// Central stall sequencer for the five-stage pipeline. It merges the ID
// hazard request and the EX multi-cycle hold into one freeze vector for the
// PC and the inter-stage latches. It also counts down multi-cycle execute
// operations such as multiply-accumulate and divide.
//
// Parameters
//   COUNT_WIDTH          width of the multi-cycle length field and counter
//
// Ports
//   clock                sole clock, rising edge
//   reset                asynchronous, active-low
//   id_stall_request     ID one-cycle hold request (level, same-cycle effect)
//   ex_multi_start       EX multi-cycle request (level, held until done)
//   ex_multi_cycles      requested stall length, sampled only on accept
//   flush                abort any operation, drop all stalls this cycle
//   stall[5:0]           freeze vector: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM,
//                        4 MEM/WB, 5 reserved (always 0)
//   ex_multi_done        one-cycle pulse: EX result valid, instruction advances
//   ex_busy              high while the sequencer is counting (BUSY)
//   o_dbg_state          current sequencer state, for observation only
//
// Optional build macro: PIPELINE_CONTROL_PERF_EN
//   stall_cycles_clear   synchronous clear of the stall counter (input)
//   stall_cycles[31:0]   saturating count of edges with stall[0]=1 (output)
//
// EX handshake: ex_multi_start is a level request that EX holds high.
// The sequencer accepts it in IDLE when the length is non-zero. It
// acknowledges with a single ex_multi_done pulse. EX drops the request
// after that pulse. The request is ignored while BUSY and during DONE,
// so a request still held in the DONE cycle cannot retrigger.
// ---------------------------------------------------------------------------
module pipeline_control #(
    parameter int COUNT_WIDTH = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   id_stall_request,
    input  logic                   ex_multi_start,
    input  logic [COUNT_WIDTH-1:0] ex_multi_cycles,
    input  logic                   flush,
`ifdef PIPELINE_CONTROL_PERF_EN
    input  logic                   stall_cycles_clear,
    output logic [31:0]            stall_cycles,
`endif
    output logic [5:0]             stall,
    output logic                   ex_multi_done,
    output logic                   ex_busy,
    output logic [1:0]             o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_busy;

    logic w_accept;
    logic w_ex_hold;

    // Accept is qualified by reset so that a request held through reset
    // cannot leak a stall while the block is being reset.
    assign w_accept  = reset && (r_state == ST_IDLE) && ex_multi_start &&
                       (ex_multi_cycles != '0);
    assign w_ex_hold = w_accept || (r_state == ST_BUSY);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (flush) begin
            // Flush wins over everything, including a simultaneous accept.
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (ex_multi_cycles == COUNT_WIDTH'(1)) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                        end else begin
                            // The accept cycle itself is the first stall cycle.
                            r_count <= ex_multi_cycles - COUNT_WIDTH'(1);
                            r_state <= ST_BUSY;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    // The count only moves while above 1, so it never wraps.
                    if (r_count == COUNT_WIDTH'(1)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count - COUNT_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // EX hold dominates the ID request. Flush and reset silence both.
    always_comb begin
        stall = 6'b000000;
        if (reset && !flush) begin
            if (w_ex_hold) begin
                stall = 6'b001111;
            end else if (id_stall_request) begin
                stall = 6'b000111;
            end
        end
    end

    assign ex_multi_done = (r_state == ST_DONE) && !flush;
    assign ex_busy       = r_busy;
    assign o_dbg_state   = r_state;

`ifdef PIPELINE_CONTROL_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if (stall_cycles_clear) begin
            r_stall_cycles <= '0;
        end else if (stall[0] && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
